// File: rtl/seq_impl_chk_pkg.sv
// Shared definitions for the seq_impl_checker slice.
//   MAX_DELAY / MAX_CH : legal upper bounds for DELAY and NUM_CH
//   clog2_min1         : index width that never collapses to zero bits
//   chk_result_e       : outcome of a b-term evaluation on one edge
package seq_impl_chk_pkg;

  localparam int MAX_DELAY = 15;
  localparam int MAX_CH    = 32;

  typedef enum logic [1:0] {
    RES_NONE,
    RES_PASS,
    RES_FAIL
  } chk_result_e;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_impl_checker_if.sv
// Bundle of control, stimulus and report signals of seq_impl_checker.
//   master : drives en, clr_cnt, valid, a, b; observes the reports
//   slave  : the checker side (consumes stimulus, drives reports)
//   pass_cnt/fail_cnt pack channel i at bits [i*CNT_W +: CNT_W].
interface seq_impl_checker_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
);
  import seq_impl_chk_pkg::*;

  localparam int CH_W = clog2_min1(NUM_CH);

  logic                      en;
  logic                      clr_cnt;
  logic [NUM_CH-1:0]         valid;
  logic [NUM_CH-1:0]         a;
  logic [NUM_CH-1:0]         b;
  logic [NUM_CH-1:0]         pass_pulse;
  logic [NUM_CH-1:0]         fail_pulse;
  logic [NUM_CH*CNT_W-1:0]   pass_cnt;
  logic [NUM_CH*CNT_W-1:0]   fail_cnt;
  logic                      first_fail_vld;
  logic [CH_W-1:0]           first_fail_ch;

  modport master (
    output en, clr_cnt, valid, a, b,
    input  pass_pulse, fail_pulse, pass_cnt, fail_cnt, first_fail_vld, first_fail_ch
  );

  modport slave (
    input  en, clr_cnt, valid, a, b,
    output pass_pulse, fail_pulse, pass_cnt, fail_cnt, first_fail_vld, first_fail_ch
  );

endinterface

// File: rtl/seq_impl_lane.sv
// One channel of the implication checker.
//   clk, rst           : clock, async active-high reset
//   en, clr_cnt        : start enable, synchronous counter clear
//   valid, a, b        : antecedent and consequent terms of this channel
//   pass_pulse/fail_pulse : registered one-cycle reports
//   pass_cnt/fail_cnt  : saturating event counters
//   fail_now           : combinational "a fail is evaluated on this edge"
module seq_impl_lane #(
  parameter int DELAY   = 3,
  parameter int OVERLAP = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr_cnt,
  input  logic             valid,
  input  logic             a,
  input  logic             b,
  output logic             pass_pulse,
  output logic             fail_pulse,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             fail_now
);
  import seq_impl_chk_pkg::*;

  logic             a_chk;     // an attempt has its a-term due on this edge
  logic             a_fail;
  logic             b_pass;
  logic             b_fail;
  logic [DELAY-1:0] vld_pipe;  // bit j: armed attempt is j+1 edges old
  chk_result_e      b_res;
  logic [1:0]       fail_inc;

  if (OVERLAP != 0) begin : g_ovl
    assign a_chk = en & valid;
  end else begin : g_novl
    // |=> form: remember the start, a is judged on the next edge even if en drops
    logic start_q;
    always_ff @(posedge clk or posedge rst)
      if (rst) start_q <= 1'b0;
      else     start_q <= en & valid;
    assign a_chk = start_q;
  end

  assign a_fail = a_chk & ~a;

  // each surviving attempt walks its own bit, so overlapping attempts never merge
  always_ff @(posedge clk or posedge rst)
    if (rst) vld_pipe <= '0;
    else     vld_pipe <= (vld_pipe << 1) | DELAY'(a_chk & a);

  always_comb begin
    b_res = RES_NONE;
    if (vld_pipe[DELAY-1]) b_res = b ? RES_PASS : RES_FAIL;
  end

  assign b_pass   = (b_res == RES_PASS);
  assign b_fail   = (b_res == RES_FAIL);
  assign fail_now = a_fail | b_fail;
  // an a-fail of a new attempt and a b-fail of an old one count separately
  assign fail_inc = {1'b0, a_fail} + {1'b0, b_fail};

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c,
                                               input logic [1:0]       inc);
    logic [CNT_W+1:0] s;
    s = {2'b00, c} + {{CNT_W{1'b0}}, inc};
    if (s[CNT_W+1:CNT_W] != 2'b00) return '1;
    return s[CNT_W-1:0];
  endfunction

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else if (clr_cnt) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else begin
      pass_cnt <= sat_add(pass_cnt, {1'b0, b_pass});
      fail_cnt <= sat_add(fail_cnt, fail_inc);
    end

  // pulses are untouched by clr_cnt
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pass_pulse <= 1'b0;
      fail_pulse <= 1'b0;
    end else begin
      pass_pulse <= b_pass;
      fail_pulse <= fail_now;
    end

endmodule

// File: rtl/seq_impl_checker.sv
// Multi-channel checker for "valid |-> a ##DELAY b" (OVERLAP=1) or
// "valid |=> a ##DELAY b" (OVERLAP=0).
//   clk, rst : clock, async active-high reset
//   bus      : seq_impl_checker_if.slave (stimulus in, pulses/counters/first-fail out)
module seq_impl_checker #(
  parameter int NUM_CH  = 4,
  parameter int DELAY   = 3,
  parameter int OVERLAP = 1,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  seq_impl_checker_if.slave  bus
);
  import seq_impl_chk_pkg::*;

  localparam int CH_W = clog2_min1(NUM_CH);

  if (NUM_CH < 1 || NUM_CH > MAX_CH || DELAY < 1 || DELAY > MAX_DELAY) begin : g_bad_param
    $error("seq_impl_checker: NUM_CH or DELAY out of range");
  end

  logic [NUM_CH-1:0]            pass_p;
  logic [NUM_CH-1:0]            fail_p;
  logic [NUM_CH-1:0]            fail_now;
  logic [NUM_CH-1:0][CNT_W-1:0] pass_c;
  logic [NUM_CH-1:0][CNT_W-1:0] fail_c;
  logic [CH_W-1:0]              low_fail;
  logic                         ff_vld;
  logic [CH_W-1:0]              ff_ch;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    seq_impl_lane #(
      .DELAY   (DELAY),
      .OVERLAP (OVERLAP),
      .CNT_W   (CNT_W)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .en         (bus.en),
      .clr_cnt    (bus.clr_cnt),
      .valid      (bus.valid[i]),
      .a          (bus.a[i]),
      .b          (bus.b[i]),
      .pass_pulse (pass_p[i]),
      .fail_pulse (fail_p[i]),
      .pass_cnt   (pass_c[i]),
      .fail_cnt   (fail_c[i]),
      .fail_now   (fail_now[i])
    );
  end

  // lowest failing channel wins; scan downward so the last hit is the lowest
  always_comb begin
    low_fail = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (fail_now[i]) low_fail = CH_W'(i);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ff_vld <= 1'b0;
      ff_ch  <= '0;
    end else if (bus.clr_cnt) begin
      ff_vld <= 1'b0;
      ff_ch  <= '0;
    end else if (!ff_vld && (|fail_now)) begin
      ff_vld <= 1'b1;
      ff_ch  <= low_fail;
    end

  assign bus.pass_pulse     = pass_p;
  assign bus.fail_pulse     = fail_p;
  assign bus.pass_cnt       = pass_c;
  assign bus.fail_cnt       = fail_c;
  assign bus.first_fail_vld = ff_vld;
  assign bus.first_fail_ch  = ff_ch;

endmodule

// File: doc/seq_impl_checker.md
Name: seq_impl_checker

Overview:
- Synthesizable, multi-channel checker for the implication property "valid |-> (a ##DELAY b)", or its non-overlapped form "|=>".
- Tracks overlapping attempts per channel and reports pass/fail pulses, saturating counters and the first failing channel.
- Sits beside DUT interfaces as an always-on protocol monitor usable in emulation/FPGA, where SVA is unavailable.

Parameters:
- NUM_CH, 4, number of independent channels (1..32)
- DELAY, 3, cycles between the a-check and the b-check (1..15)
- OVERLAP, 1, 1 = |-> (a checked on the antecedent edge); 0 = |=> (a checked one edge later)
- CNT_W, 16, width of each pass/fail counter

Ports:
- clk  in  1  sampling clock; all checks on posedge
- rst  in  1  asynchronous, active-high reset
- en  in  1  allows new attempts to start
- clr_cnt  in  1  synchronous clear of counters and first-fail capture
- valid  in  NUM_CH  per-channel antecedent
- a  in  NUM_CH  per-channel first consequent term
- b  in  NUM_CH  per-channel second consequent term
- pass_pulse  out  NUM_CH  one-cycle pass indication
- fail_pulse  out  NUM_CH  one-cycle fail indication
- pass_cnt  out  NUM_CH*CNT_W  packed per-channel pass counters; channel i occupies bits [i*CNT_W +: CNT_W]
- fail_cnt  out  NUM_CH*CNT_W  packed per-channel fail counters, same packing
- first_fail_vld  out  1  sticky: a fail has occurred since reset/clear
- first_fail_ch  out  $clog2(NUM_CH) (min 1)  lowest-index channel failing on the first fail edge

Behaviour:
- Reset values: all outputs 0; all pending attempts discarded. Reset asserted mid-attempt kills that attempt with no report.
- Attempt start: on an edge where en=1 and valid[i]=1. If valid=0, the edge produces no report (vacuous).
- OVERLAP=1:
  - a[i] is sampled on the start edge k.
  - a=0 fails the attempt on edge k.
  - a=1 arms slot 0 of a DELAY-deep per-channel pending shift register.
  - b[i] is sampled on edge k+DELAY: 1 = pass, 0 = fail.
- OVERLAP=0:
  - The start is recorded on edge k.
  - a is sampled on edge k+1 (0 = fail then).
  - b is sampled on edge k+1+DELAY.
- Report timing: pass_pulse/fail_pulse are registered. An evaluation on edge n makes the pulse high from edge n for exactly one cycle.
- Overlap: one attempt may start per edge per channel. Up to DELAY+1 attempts are in flight per channel. Attempts are independent and never merge.
- Simultaneous events on one edge and channel:
  - An immediate a-fail and a completing b-evaluation each count separately.
  - fail_cnt may increment by 2 on one edge.
  - pass_pulse and fail_pulse may both be high.
- Counters: saturate at 2^CNT_W-1, no wrap.
- clr_cnt=1:
  - Zeroes counters, first_fail_vld and first_fail_ch on that edge, with priority over same-edge increments.
  - Does not disturb pending attempts or pulses.
- en=0:
  - Suppresses starts only; in-flight attempts complete and report.
  - When OVERLAP=0, the a-check of an attempt already started still occurs.
- first_fail: on the first edge with any fail while first_fail_vld=0, latch the lowest failing channel index and set vld. Later fails are ignored until clear/reset.

Decomposition:
- Package seq_impl_chk_pkg:
  - constants MAX_DELAY=15 and MAX_CH=32
  - function clog2_min1
  - typedef chk_result_e {RES_NONE, RES_PASS, RES_FAIL}
- Sub-module seq_impl_lane:
  - one channel: pending shift register, a/b evaluation, two saturating counters
  - instantiated NUM_CH times via generate
  - the top holds the first-fail priority encoder

Test Plan:
- DELAY=3, OVERLAP=1; ch0 valid=1,a=1 at edge k only; b=1 at edge k+3 -> pass_pulse[0] high one cycle from k+3; pass_cnt0=1, fail_cnt0=0, first_fail_vld=0.
- Same stimulus with b=0 at k+3 -> fail_pulse[0] at k+3; fail_cnt0=1; first_fail_vld=1, first_fail_ch=0.
- Overlap: ch2 valid=a=1 on edges k..k+3; b on edges k+3..k+6 = 1,0,1,1 -> pulses pass, fail, pass, pass; pass_cnt2=3, fail_cnt2=1; ch0/1/3 counters stay 0.
- Simultaneous: ch1 attempt from k-3 with b=1 at k, plus valid=1,a=0 at k -> pass_pulse[1] and fail_pulse[1] both high; pass_cnt1=1, fail_cnt1=1. Same edge with ch3 also failing -> first_fail_ch=1.
- OVERLAP=0, DELAY=2: valid=1 at edge k, a=1 at k+1, b=1 at k+3 -> pass at k+3. Repeat with a=0 at k+1 -> fail at k+1, no report at k+3.
- CNT_W=2: 5 consecutive passes -> pass_cnt0=3. Then clr_cnt during an in-flight attempt -> counters 0, and that attempt still reports with pass_cnt0=1. Then rst mid-flight -> no pulse, all outputs 0.
